// File: rtl/bcd_counter_scanner_if.sv
// Counter control, load data and display-drive signals of the BCD counter/scanner.
// The master drives the controls; the slave (the counter) returns count and display outputs.
interface bcd_counter_scanner_if;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] D;
  logic        blank_lz;
  logic [15:0] count;
  logic        carry;
  logic [3:0]  X;
  logic [3:0]  AN;

  modport master (
    output en, up, load, D, blank_lz,
    input  count, carry, X, AN
  );

  modport slave (
    input  en, up, load, D, blank_lz,
    output count, carry, X, AN
  );
endinterface

// File: rtl/bcd_counter_scanner.sv
// Four-digit BCD up/down counter with a time-multiplexed digit scanner that feeds
// a 7-segment decoder (X) and drives one-hot digit enables (AN) with leading-zero blanking.
module bcd_counter_scanner #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input logic                 clk,
  input logic                 rst,
  bcd_counter_scanner_if.slave bus
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] count_q;
  logic        carry_q;
  logic [15:0] count_inc;
  logic [15:0] count_dec;
  logic [15:0] d_clean;
  logic        inc_wrap;
  logic        dec_wrap;

  logic [15:0] div_q;
  logic [1:0]  idx_q;
  logic [1:0]  idx_next;
  logic        slot_end;
  logic [3:0]  an_q;
  logic [3:0]  an_next;
  logic [15:0] upper_digits;
  logic        blanked;
  logic [3:0]  x_mux;

  // Ripple increment/decrement: the carry/borrow flag is cleared by the first
  // digit that does not roll over; if it survives all four digits, the counter wrapped.
  always_comb begin
    count_inc = count_q;
    count_dec = count_q;
    inc_wrap  = 1'b1;
    dec_wrap  = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (inc_wrap) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          inc_wrap            = 1'b0;
        end
      end
      if (dec_wrap) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          dec_wrap            = 1'b0;
        end
      end
    end
  end

  always_comb begin
    d_clean = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      d_clean[4*i +: 4] = (bus.D[4*i +: 4] > 4'd9) ? 4'd0 : bus.D[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else if (bus.load) begin
      count_q <= d_clean;
      carry_q <= 1'b0;
    end else if (bus.en) begin
      count_q <= bus.up ? count_inc : count_dec;
      carry_q <= bus.up ? inc_wrap : dec_wrap;
    end else begin
      carry_q <= 1'b0;
    end
  end

  assign slot_end = (div_q == DIV_LAST);
  assign idx_next = slot_end ? idx_q + 2'd1 : idx_q;

  // AN is registered from the upcoming slot index and the current count, so a
  // blanking change caused by count or blank_lz shows one cycle later.
  always_comb begin
    upper_digits = count_q >> {idx_next, 2'b00};
    blanked      = bus.blank_lz && (idx_next != 2'd0) && (upper_digits == '0);
    an_next      = blanked ? '0 : (4'b0001 << idx_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      an_q  <= 4'b0001;
    end else begin
      div_q <= slot_end ? '0 : div_q + 16'd1;
      idx_q <= idx_next;
      an_q  <= an_next;
    end
  end

  always_comb begin
    x_mux = count_q[{idx_q, 2'b00} +: 4];
  end

  assign bus.count = count_q;
  assign bus.carry = carry_q;
  assign bus.X     = x_mux;
  assign bus.AN    = an_q;

endmodule
